imem_fetch_ctrl: RTL and testbench

// - Instruction-fetch sequencer for the byte-addressed, combinational-read instruction memory.
// - Owns the PC and drives the memory enable and address; a big-endian 32-bit word is returned in the same cycle.
// - Registers each word with its PC and presents it to decode over a valid/ready handshake.
// - Handles branch/jump redirects, halt requests, and fetch faults.

---
 rtl/imem_fetch_ctrl.sv | 133 +++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, reads a combinational imem and hands words to decode.
// Optional IFETCH_PERF_CNT_EN adds fetch_cnt / flush_cnt performance counters.
module imem_fetch_ctrl #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned MEM_BYTES = 128
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_reg,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        halt,
   output logic        fetch_fault
`ifdef IFETCH_PERF_CNT_EN
   ,
   output logic [31:0] fetch_cnt,
   output logic [31:0] flush_cnt
`endif
);

   typedef enum logic [1:0] {StIdle, StFetch, StFault} state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] ipc_q, ipc_d;
   logic        valid_q, valid_d;
   logic        fault_q, fault_d;
   logic        fire;
   logic        flush;

   // Widened add so a PC near 2^32 cannot wrap into the legal range.
   function automatic logic addr_ok(input logic [31:0] a);
      logic [32:0] last_byte;
      last_byte = {1'b0, a} + 33'd3;
      return (a[1:0] == 2'b00) && (last_byte < 33'(MEM_BYTES));
   endfunction

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      ipc_d   = ipc_q;
      valid_d = valid_q;
      fault_d = fault_q;
      fire    = 1'b0;
      flush   = 1'b0;
      case (state_q)
         StIdle: state_d = StFetch;
         StFetch, StFault: begin
            if (redirect_valid) begin
               flush   = valid_q;
               pc_d    = redirect_pc;
               valid_d = 1'b0;
               if (addr_ok(redirect_pc)) begin
                  state_d = StFetch;
                  fault_d = 1'b0;
               end else begin
                  state_d = StFault;
                  fault_d = 1'b1;
               end
            end else begin
               if (valid_q && if_ready) valid_d = 1'b0;
               if (state_q == StFetch && !halt) begin
                  if (!addr_ok(pc_q)) begin
                     state_d = StFault;
                     fault_d = 1'b1;
                  end else if (!valid_q || if_ready) begin
                     fire    = 1'b1;
                     instr_d = imem_data;
                     ipc_d   = pc_q;
                     valid_d = 1'b1;
                     pc_d    = pc_q + 32'd4;
                  end
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         pc_q    <= RESET_PC;
         instr_q <= 32'h0;
         ipc_q   <= 32'h0;
         valid_q <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         ipc_q   <= ipc_d;
         valid_q <= valid_d;
         fault_q <= fault_d;
      end
   end

`ifdef IFETCH_PERF_CNT_EN
   logic [31:0] fetch_cnt_q, flush_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_cnt_q <= 32'h0;
         flush_cnt_q <= 32'h0;
      end else begin
         if (fire)  fetch_cnt_q <= fetch_cnt_q + 32'd1;
         if (flush) flush_cnt_q <= flush_cnt_q + 32'd1;
      end
   end

   assign fetch_cnt = fetch_cnt_q;
   assign flush_cnt = flush_cnt_q;
`else
   logic unused_flush;
   assign unused_flush = flush;
`endif

   assign imem_reg    = fire && !rst;
   assign imem_addr   = pc_q;
   assign if_valid    = valid_q;
   assign if_instr    = instr_q;
   assign if_pc       = ipc_q;
   assign fetch_fault = fault_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_imem_fetch_ctrl;
   localparam int unsigned MEM_BYTES = 128;
   localparam int ModeBoot  = 0;
   localparam int ModeRun   = 1;
   localparam int ModeFault = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_reg;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic        if_valid;
   logic        if_ready = 1'b1;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        halt = 1'b0;
   logic        fetch_fault;
`ifdef IFETCH_PERF_CNT_EN
   logic [31:0] fetch_cnt;
   logic [31:0] flush_cnt;
`endif

   imem_fetch_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .imem_reg       (imem_reg),
      .imem_addr      (imem_addr),
      .imem_data      (imem_data),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_instr       (if_instr),
      .if_pc          (if_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt           (halt),
      .fetch_fault    (fetch_fault)
`ifdef IFETCH_PERF_CNT_EN
      ,
      .fetch_cnt      (fetch_cnt),
      .flush_cnt      (flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   logic [31:0] mem [0:MEM_BYTES/4-1];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a < MEM_BYTES) return mem[a[6:2]];
      return 32'hDEAD_BEEF;
   endfunction

   always_comb imem_data = (imem_addr < MEM_BYTES) ? mem[imem_addr[6:2]] : 32'hDEAD_BEEF;

   int n_vec  = 0;
   int n_miss = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: what decode must see, derived from the fetch rules.
   bit          m_init = 0;
   int          m_mode;
   logic [31:0] m_pc, m_instr, m_ipc;
   bit          m_valid, m_fault;
   logic [31:0] m_fetches, m_flushes;

   function automatic bit legal(input logic [31:0] a);
      return (a % 4 == 0) && (64'(a) + 64'd3 < 64'(MEM_BYTES));
   endfunction

   function automatic bit exp_fire();
      return !rst && m_mode == ModeRun && !halt && !redirect_valid &&
             (!m_valid || if_ready) && legal(m_pc);
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_init = 1; m_mode = ModeBoot; m_pc = 32'h0; m_instr = 32'h0; m_ipc = 32'h0;
         m_valid = 0; m_fault = 0; m_fetches = 0; m_flushes = 0;
      end else if (m_init) begin
         if (m_mode == ModeBoot) begin
            m_mode = ModeRun;
         end else if (redirect_valid) begin
            if (m_valid) m_flushes++;
            m_valid = 0;
            m_pc    = redirect_pc;
            m_fault = !legal(redirect_pc);
            m_mode  = m_fault ? ModeFault : ModeRun;
         end else begin
            bit f;
            f = exp_fire();
            if (m_valid && if_ready) m_valid = 0;
            if (m_mode == ModeRun && !halt && !legal(m_pc)) begin
               m_mode = ModeFault; m_fault = 1;
            end
            if (f) begin
               m_instr = mem_word(m_pc); m_ipc = m_pc; m_valid = 1;
               m_pc = m_pc + 4; m_fetches++;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (m_init) begin
         chk("imem_reg", 32'(imem_reg), 32'(exp_fire()));
         chk("imem_addr", imem_addr, m_pc);
         chk("if_valid", 32'(if_valid), 32'(m_valid));
         chk("if_instr", if_instr, m_instr);
         chk("if_pc", if_pc, m_ipc);
         chk("fetch_fault", 32'(fetch_fault), 32'(m_fault));
`ifdef IFETCH_PERF_CNT_EN
         chk("fetch_cnt", fetch_cnt, m_fetches);
         chk("flush_cnt", flush_cnt, m_flushes);
`endif
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic look();
      @(negedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < MEM_BYTES / 4; i++) mem[i] = 32'hC0DE_0000 + 32'(i * 4);

      // Reset release and streaming
      step(); step(); rst = 1'b0; look();
      chk("idle_reg", 32'(imem_reg), 32'd0);
      chk("rst_valid", 32'(if_valid), 32'd0);
      chk("rst_fault", 32'(fetch_fault), 32'd0);
      chk("rst_instr", if_instr, 32'h0);
      step(); look();
      chk("first_reg", 32'(imem_reg), 32'd1);
      chk("first_addr", imem_addr, 32'h0);
      step(); look();
      chk("pc0", if_pc, 32'h0);
      chk("instr0", if_instr, 32'hC0DE_0000);
      step(); if_ready = 1'b0; look();
      chk("pc4", if_pc, 32'h4);
      chk("stall_reg", 32'(imem_reg), 32'd0);
      step(); look();
      chk("stall_instr", if_instr, 32'hC0DE_0004);
      chk("stall_addr", imem_addr, 32'h8);
      step(); look();
      chk("stall_pc", if_pc, 32'h4);
      step(); if_ready = 1'b1; look();
      chk("resume_reg", 32'(imem_reg), 32'd1);
      step(); redirect_valid = 1'b1; redirect_pc = 32'h20; look();
      chk("pc8", if_pc, 32'h8);
      chk("redir_reg", 32'(imem_reg), 32'd0);
      step(); redirect_valid = 1'b0; look();
      chk("flushed", 32'(if_valid), 32'd0);
      chk("target_addr", imem_addr, 32'h20);
`ifdef IFETCH_PERF_CNT_EN
      chk("flush_cnt1", flush_cnt, 32'd1);
`endif
      step(); look();
      chk("pc20", if_pc, 32'h20);
      // Misaligned redirect faults, aligned redirect clears
      step(); redirect_valid = 1'b1; redirect_pc = 32'h22; look();
      step(); redirect_valid = 1'b0; look();
      chk("mis_fault", 32'(fetch_fault), 32'd1);
      chk("mis_reg", 32'(imem_reg), 32'd0);
      step(); look();
      chk("fault_hold", 32'(fetch_fault), 32'd1);
      step(); redirect_valid = 1'b1; redirect_pc = 32'h0; look();
      step(); redirect_valid = 1'b0; look();
      chk("clear_fault", 32'(fetch_fault), 32'd0);
      chk("clear_reg", 32'(imem_reg), 32'd1);
      step(); look();
      chk("pc0_again", if_pc, 32'h0);
      // Fall off the end of memory
      step(); redirect_valid = 1'b1; redirect_pc = 32'h70; look();
      step(); redirect_valid = 1'b0; look();
      step(); look();
      step(); look();
      step(); look();
      chk("last_addr", imem_addr, 32'h7C);
      chk("last_reg", 32'(imem_reg), 32'd1);
      step(); look();
      chk("pc7c", if_pc, 32'h7C);
      chk("end_reg", 32'(imem_reg), 32'd0);
      chk("end_addr", imem_addr, 32'h80);
      step(); look();
      chk("end_fault", 32'(fetch_fault), 32'd1);
      chk("end_reg2", 32'(imem_reg), 32'd0);
      // Halt mid-stream
      step(); redirect_valid = 1'b1; redirect_pc = 32'h8; look();
      step(); redirect_valid = 1'b0; look();
      step(); look();
      step(); halt = 1'b1; if_ready = 1'b0; look();
      chk("halt_pc", if_pc, 32'hC);
      chk("halt_reg", 32'(imem_reg), 32'd0);
      chk("halt_addr", imem_addr, 32'h10);
      step(); look();
      step(); if_ready = 1'b1; look();
      chk("halt_acc_reg", 32'(imem_reg), 32'd0);
      step(); look();
      chk("halt_drained", 32'(if_valid), 32'd0);
      step(); halt = 1'b0; look();
      chk("unhalt_reg", 32'(imem_reg), 32'd1);
      step(); look();
      chk("unhalt_pc", if_pc, 32'h10);

      // Randomized traffic
      for (int i = 0; i < 4000; i++) begin
         step();
         rst            = ($urandom_range(0, 299) == 0);
         if_ready       = ($urandom_range(0, 3) != 0);
         halt           = ($urandom_range(0, 9) == 0);
         redirect_valid = ($urandom_range(0, 19) == 0);
         case ($urandom_range(0, 5))
            0:       redirect_pc = $urandom;
            1:       redirect_pc = 32'($urandom_range(0, 31)) * 4 + 32'($urandom_range(1, 3));
            2:       redirect_pc = 32'($urandom_range(28, 40)) * 4;
            3:       redirect_pc = 32'hFFFF_FFFC;
            default: redirect_pc = 32'($urandom_range(0, 31)) * 4;
         endcase
      end
      step();
      rst = 1'b0; redirect_valid = 1'b0; halt = 1'b0;
      look();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
